baud_frac_tick_gen: RTL and testbench

- Runtime-programmable fractional modulus counter; successor to the fixed-modulus tick counter.
- Generates the UART oversample tick (s_tick) and the bit-period tick (b_tick) from clk.
- Divisor is integer plus fractional part, so baud rates are exact on average.
- Divisor is reprogrammable at runtime without glitching the current period. Sits between the CSR block and the uart_rx/uart_tx engines.

---
 rtl/baud_frac_tick_gen.sv | 113 +++++++++++
 tb/tb_baud_frac_tick_gen.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_frac_tick_gen.sv
// Fractional baud tick generator: oversample tick (s_tick) and bit tick (b_tick)
// from clk, with a runtime divisor double-buffered through a shadow register.
module baud_frac_tick_gen #(
  parameter int DW       = 16,
  parameter int FW       = 4,
  parameter int OVS      = 16,
  parameter int DIV_RST  = 326,
  parameter int FRAC_RST = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    sync_clr,
  input  logic                    div_wr,
  input  logic [DW-1:0]           div_int,
  input  logic [FW-1:0]           div_frac,
  output logic                    s_tick,
  output logic                    b_tick,
  output logic                    div_busy,
  output logic [DW-1:0]           q,
  output logic [$clog2(OVS)-1:0]  b_cnt
);

  localparam int BW = $clog2(OVS);
  localparam logic [BW-1:0] B_LAST = BW'(OVS - 1);

  logic [DW-1:0] r;
  logic [DW-1:0] act_int;
  logic [DW-1:0] pend_int;
  logic [FW-1:0] acc;
  logic [FW-1:0] act_frac;
  logic [FW-1:0] pend_frac;
  logic [BW-1:0] b;
  logic          ext;
  logic          pend;
  logic [DW:0]   last;
  logic          at_last;
  logic          wrap;
  logic          b_wrap;
  logic          xfer;
  logic [FW:0]   acc_sum;

  // Last count of the current period; a zero integer divisor behaves as one.
  function automatic logic [DW:0] last_count(input logic [DW-1:0] div, input logic extra);
    logic [DW-1:0] d;
    d = (div == '0) ? DW'(1) : div;
    return {1'b0, d} + {{DW{1'b0}}, extra} - (DW+1)'(1);
  endfunction

  // >= rather than == so a divisor shrunk while idle still wraps promptly.
  assign last    = last_count(act_int, ext);
  assign at_last = ({1'b0, r} >= last);
  assign wrap    = en & ~sync_clr & at_last;
  assign b_wrap  = (b == B_LAST);
  assign xfer    = pend & (wrap | ~en | sync_clr);
  assign acc_sum = {1'b0, acc} + {1'b0, act_frac};

  assign s_tick   = reset & wrap;
  assign b_tick   = s_tick & b_wrap;
  assign div_busy = pend;
  assign q        = r;
  assign b_cnt    = b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r   <= '0;
      b   <= '0;
      acc <= '0;
      ext <= 1'b0;
    end else if (sync_clr) begin
      r   <= '0;
      b   <= '0;
      acc <= '0;
      ext <= 1'b0;
    end else if (en) begin
      if (at_last) begin
        r   <= '0;
        acc <= acc_sum[FW-1:0];
        ext <= acc_sum[FW];
        b   <= b_wrap ? '0 : b + BW'(1);
      end else begin
        r <= r + DW'(1);
      end
    end
  end

  // A write coinciding with a transfer lands in the shadow and stays pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_int  <= DW'(DIV_RST);
      act_frac <= FW'(FRAC_RST);
      pend     <= 1'b0;
    end else begin
      if (xfer) begin
        act_int  <= pend_int;
        act_frac <= pend_frac;
      end
      if (div_wr) begin
        pend <= 1'b1;
      end else if (xfer) begin
        pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (div_wr) begin
      pend_int  <= div_int;
      pend_frac <= div_frac;
    end
  end

endmodule

// File: tb/tb_baud_frac_tick_gen.sv
// Bench for baud_frac_tick_gen: period-level reference model checked every cycle,
// plus directed scenarios with hand-computed tick intervals.
module tb_baud_frac_tick_gen;

  localparam int DW = 16;
  localparam int FW = 4;
  localparam int OVS = 16;
  localparam int DIV_RST = 5;
  localparam int FRAC_RST = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          sync_clr = 1'b0;
  logic          div_wr = 1'b0;
  logic [DW-1:0] div_int = '0;
  logic [FW-1:0] div_frac = '0;
  logic          s_tick;
  logic          b_tick;
  logic          div_busy;
  logic [DW-1:0] q;
  logic [3:0]    b_cnt;

  baud_frac_tick_gen #(
    .DW(DW), .FW(FW), .OVS(OVS), .DIV_RST(DIV_RST), .FRAC_RST(FRAC_RST)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr),
    .div_wr(div_wr), .div_int(div_int), .div_frac(div_frac),
    .s_tick(s_tick), .b_tick(b_tick), .div_busy(div_busy),
    .q(q), .b_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: position inside the current period, and the total of all
  // fractional parts added since the last clear. A period is one cycle longer
  // whenever that running total crosses a multiple of 2^FW.
  int m_pos = 0;
  int m_b = 0;
  int m_sum = 0;
  int m_ext = 0;
  int m_I = DIV_RST;
  int m_F = FRAC_RST;
  int m_pI = 0;
  int m_pF = 0;
  bit m_pend = 1'b0;
  bit m_tk;
  bit m_xf;
  int m_old;

  function automatic int m_len();
    return ((m_I == 0) ? 1 : m_I) + m_ext;
  endfunction

  function automatic bit m_tick();
    return reset && en && !sync_clr && (m_pos == m_len() - 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pos = 0; m_b = 0; m_sum = 0; m_ext = 0;
      m_I = DIV_RST; m_F = FRAC_RST; m_pend = 1'b0;
    end else begin
      m_tk = m_tick();
      m_xf = m_pend && (m_tk || !en || sync_clr);
      if (sync_clr) begin
        m_pos = 0; m_b = 0; m_sum = 0; m_ext = 0;
      end else if (en) begin
        if (m_tk) begin
          m_old = m_sum;
          m_sum = m_sum + m_F;
          m_ext = m_sum / (1 << FW) - m_old / (1 << FW);
          m_pos = 0;
          m_b = (m_b + 1) % OVS;
        end else begin
          m_pos = m_pos + 1;
        end
      end
      if (m_xf) begin
        m_I = m_pI; m_F = m_pF; m_pend = 1'b0;
      end
      if (div_wr) begin
        m_pI = div_int; m_pF = div_frac; m_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_s_tick", s_tick, m_tick());
    check("cyc_b_tick", b_tick, m_tick() && (m_b == OVS - 1));
    check("cyc_q", q, m_pos);
    check("cyc_b_cnt", b_cnt, m_b);
    check("cyc_div_busy", div_busy, m_pend);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!s_tick && n < 100);
    check("tick_seen", s_tick, 1);
  endtask

  task automatic wait_q(input int v);
    int k;
    k = 0;
    while (q !== v && k < 100) begin
      step();
      k++;
    end
    check("q_reach", q, v);
  endtask

  int exp2[7] = '{3, 3, 4, 3, 4, 3, 4};
  int n;
  int bsave;

  initial begin
    #1 reset = 1'b0;
    en = 1'b1;
    repeat (3) step();
    check("rst_q", q, 0);
    check("rst_b_cnt", b_cnt, 0);
    check("rst_busy", div_busy, 0);
    check("rst_s_tick", s_tick, 0);
    check("rst_b_tick", b_tick, 0);
    reset = 1'b1;

    // Divisor 5: ticks on cycles 5,10,...; bit tick on the 16th (cycle 80).
    for (int k = 1; k <= 16; k++) begin
      wait_tick(n);
      check("t1_interval", (k == 1) ? n + 1 : n, 5);
      check("t1_b_tick", b_tick, (k == 16));
      if (k == 16) check("t1_b_cnt", b_cnt, 15);
    end
    step();
    check("t1_q_wrap", q, 0);
    check("t1_b_wrap", b_cnt, 0);

    // 3 + 8/16 written while idle: applied on the next idle edge.
    en = 1'b0; div_wr = 1'b1; div_int = 3; div_frac = 8;
    step();
    div_wr = 1'b0;
    check("t2_busy_set", div_busy, 1);
    check("t2_q_hold", q, 0);
    step();
    check("t2_busy_clr", div_busy, 0);
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_tick(n);
      check("t2_interval", (i == 0) ? n + 1 : n, exp2[i]);
    end

    // Clear to a known phase with divisor 5, then shrink to 2 mid-period.
    sync_clr = 1'b1; div_wr = 1'b1; div_int = 5; div_frac = 0;
    step();
    div_wr = 1'b0;
    check("t3_busy_set", div_busy, 1);
    step();
    check("t3_busy_clr", div_busy, 0);
    sync_clr = 1'b0;
    check("t3_q_clr", q, 0);
    wait_q(1);
    div_wr = 1'b1; div_int = 2;
    step();
    div_wr = 1'b0;
    check("t3_busy_mid", div_busy, 1);
    check("t3_q_mid", q, 2);
    wait_tick(n);
    check("t3_old_period", n, 2);
    check("t3_busy_wrap", div_busy, 1);
    step();
    check("t3_busy_done", div_busy, 0);
    check("t3_q_new", q, 0);
    wait_tick(n);
    check("t3_new_first", n, 1);
    wait_tick(n);
    check("t3_new_int", n, 2);
    wait_tick(n);
    check("t3_new_int", n, 2);

    // Go to divisor 6, then two writes: one in the wrap cycle, one 2 cycles later.
    div_wr = 1'b1; div_int = 6;
    step();
    div_wr = 1'b0;
    wait_tick(n);
    check("t4_pre_tick", n, 1);
    step();
    check("t4_busy_clr", div_busy, 0);
    check("t4_q0", q, 0);
    wait_tick(n);
    check("t4_six", n, 5);
    div_wr = 1'b1; div_int = 3;
    step();
    div_wr = 1'b0;
    check("t4_busy_a", div_busy, 1);
    check("t4_q_a", q, 0);
    step();
    check("t4_busy_b", div_busy, 1);
    check("t4_q_b", q, 1);
    div_wr = 1'b1; div_int = 4;
    step();
    div_wr = 1'b0;
    check("t4_busy_c", div_busy, 1);
    check("t4_q_c", q, 2);
    wait_tick(n);
    check("t4_old_end", n, 3);
    check("t4_busy_wrap", div_busy, 1);
    step();
    check("t4_busy_done", div_busy, 0);
    wait_tick(n);
    check("t4_four_first", n, 3);
    wait_tick(n);
    check("t4_four", n, 4);

    // Freeze for 7 cycles at q=2, resume, then clear on the wrap cycle.
    wait_q(2);
    bsave = m_b;
    en = 1'b0;
    repeat (7) begin
      step();
      check("t5_q_frozen", q, 2);
      check("t5_b_frozen", b_cnt, bsave);
      check("t5_no_tick", s_tick, 0);
    end
    en = 1'b1;
    step();
    check("t5_q_resume", q, 3);
    check("t5_tick_resume", s_tick, 1);
    sync_clr = 1'b1;
    #1;
    check("t5_clr_no_tick", s_tick, 0);
    step();
    sync_clr = 1'b0;
    check("t5_clr_q", q, 0);
    check("t5_clr_b", b_cnt, 0);

    // Async reset mid-period discards a pending divisor.
    wait_q(1);
    div_wr = 1'b1; div_int = 2;
    step();
    div_wr = 1'b0;
    check("t6_busy_set", div_busy, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_q", q, 0);
    check("t6_async_b", b_cnt, 0);
    check("t6_async_busy", div_busy, 0);
    check("t6_async_s", s_tick, 0);
    check("t6_async_bt", b_tick, 0);
    step();
    step();
    reset = 1'b1;
    check("t6_busy_rel", div_busy, 0);
    wait_tick(n);
    check("t6_div_rst_first", n, 4);
    wait_tick(n);
    check("t6_div_rst", n, 5);

    // Divisor 0 behaves as 1: a tick every cycle.
    div_wr = 1'b1; div_int = 0; div_frac = 0;
    step();
    div_wr = 1'b0;
    wait_tick(n);
    check("t6_last_five", n, 4);
    step();
    repeat (5) begin
      check("t6_zero_tick", s_tick, 1);
      check("t6_zero_q", q, 0);
      step();
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
